code_loader: RTL and testbench

CODE_LOADER -- requirements
Module: code_loader

---
 rtl/code_loader.sv | 165 ++++++++++++++++
 tb/tb_code_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | code_loader: packs a 32-bit beat stream into 64-bit instruction writes |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module code_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH/2-1:0] s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_en,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     prog_len,
  output logic                    err_odd,
  output logic                    err_ovf
);

  localparam int                  SW    = DATA_WIDTH / 2;
  localparam logic [ADDR_WIDTH:0] FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     ptr_q, ptr_d;
  logic [SW-1:0]           hi_q, hi_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    err_odd_q, err_odd_d;
  logic                    err_ovf_q, err_ovf_d;

  logic accept;
  logic full;

  assign s_tready = (state_q != IDLE);
  assign accept   = s_tvalid && s_tready;
  assign full     = (ptr_q == FULL);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_odd_d = err_odd_q;
    err_ovf_d = err_ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = HI;
          ptr_d     = '0;
          err_odd_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end

      HI: begin
        if (accept) begin
          if (full) begin
            // Memory is full: stop writing, swallow the rest of the program.
            err_ovf_d = 1'b1;
            if (s_tlast) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end else if (s_tlast) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[ADDR_WIDTH-1:0];
            wr_data_d = {s_tdata, {SW{1'b0}}};
            ptr_d     = ptr_q + ONE;
            err_odd_d = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            hi_d    = s_tdata;
            state_d = LO;
          end
        end
      end

      LO: begin
        if (accept) begin
          if (!full) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[ADDR_WIDTH-1:0];
            wr_data_d = {hi_q, s_tdata};
            ptr_d     = ptr_q + ONE;
          end
          if (s_tlast) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = HI;
          end
        end
      end

      DRAIN: begin
        if (accept && s_tlast) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hi_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_odd_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_odd_q <= err_odd_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign prog_len = ptr_q;
  assign err_odd  = err_odd_q;
  assign err_ovf  = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_code_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_code_loader: scoreboard bench for code_loader (default and DEPTH=4) |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_code_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast;

  logic        rdy_a, wa_en, busy_a, done_a, eodd_a, eovf_a;
  logic [9:0]  wa_addr;
  logic [63:0] wa_data;
  logic [10:0] plen_a;

  logic        rdy_b, wb_en, busy_b, done_b, eodd_b, eovf_b;
  logic [2:0]  wb_addr;
  logic [63:0] wb_data;
  logic [3:0]  plen_b;

  code_loader u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(rdy_a),
    .wr_addr(wa_addr), .wr_data(wa_data), .wr_en(wa_en),
    .busy(busy_a), .done(done_a), .prog_len(plen_a),
    .err_odd(eodd_a), .err_ovf(eovf_a)
  );

  code_loader #(.ADDR_WIDTH(3), .DATA_WIDTH(64), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(rdy_b),
    .wr_addr(wb_addr), .wr_data(wb_data), .wr_en(wb_en),
    .busy(busy_b), .done(done_b), .prog_len(plen_b),
    .err_odd(eodd_b), .err_ovf(eovf_b)
  );

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [63:0] data;
    logic        done;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic wr, input logic [9:0] addr,
                              input logic [63:0] data, input logic dn);
    exp_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.done = dn;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every wr_en or done event must match the head of the queue.
  always @(posedge clk) begin
    #1;
    if (wa_en || done_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL mon_a unexpected: wr_en=%b done=%b addr=%h data=%h",
                 wa_en, done_a, wa_addr, wa_data);
      end else begin
        ea = qa.pop_front();
        if (wa_en !== ea.wr || done_a !== ea.done ||
            (ea.wr && (wa_addr !== ea.addr || wa_data !== ea.data))) begin
          errors++;
          $display("FAIL mon_a event: got wr=%b done=%b addr=%h data=%h expected wr=%b done=%b addr=%h data=%h",
                   wa_en, done_a, wa_addr, wa_data, ea.wr, ea.done, ea.addr, ea.data);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (wb_en || done_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL mon_b unexpected: wr_en=%b done=%b addr=%h data=%h",
                 wb_en, done_b, wb_addr, wb_data);
      end else begin
        eb = qb.pop_front();
        if (wb_en !== eb.wr || done_b !== eb.done ||
            (eb.wr && ({7'd0, wb_addr} !== eb.addr || wb_data !== eb.data))) begin
          errors++;
          $display("FAIL mon_b event: got wr=%b done=%b addr=%h data=%h expected wr=%b done=%b addr=%h data=%h",
                   wb_en, done_b, wb_addr, wb_data, eb.wr, eb.done, eb.addr, eb.data);
        end
      end
    end
  end

  // Drive one beat from a negedge; it is taken on the next posedge where ready is high.
  task automatic beat(input bit sel, input logic [31:0] d, input bit last, input bit throttle);
    int n;
    n = 0;
    if (throttle) repeat ($urandom_range(0, 3)) @(negedge clk);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!(sel ? rdy_b : rdy_a)) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: ready=0 after %0d cycles, required 1", n);
        s_tvalid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pulse(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_tready"},  {63'd0, rdy_a},  64'd0);
    chk({tag, "_wr_en"},   {63'd0, wa_en},  64'd0);
    chk({tag, "_busy"},    {63'd0, busy_a}, 64'd0);
    chk({tag, "_done"},    {63'd0, done_a}, 64'd0);
    chk({tag, "_prog_len"}, {53'd0, plen_a}, 64'd0);
    chk({tag, "_err_odd"}, {63'd0, eodd_a}, 64'd0);
    chk({tag, "_err_ovf"}, {63'd0, eovf_a}, 64'd0);
    chk({tag, "_wr_addr"}, {54'd0, wa_addr}, 64'd0);
    chk({tag, "_wr_data"}, wa_data, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two-instruction load
    pulse(0);
    chk("t36_busy", {63'd0, busy_a}, 64'd1);
    qa.push_back(mk(1'b1, 10'd0, 64'hAAAA0000_AAAA0001, 1'b0));
    qa.push_back(mk(1'b1, 10'd1, 64'hBBBB0000_BBBB0001, 1'b1));
    beat(0, 32'hAAAA0000, 0, 0);
    beat(0, 32'hAAAA0001, 0, 0);
    beat(0, 32'hBBBB0000, 0, 0);
    beat(0, 32'hBBBB0001, 1, 0);
    repeat (3) @(negedge clk);
    chk("t36_prog_len", {53'd0, plen_a}, 64'd2);
    chk("t36_err_odd",  {63'd0, eodd_a}, 64'd0);
    chk("t36_busy_end", {63'd0, busy_a}, 64'd0);

    // Odd beat count
    pulse(0);
    qa.push_back(mk(1'b1, 10'd0, 64'h00000011_00000022, 1'b0));
    qa.push_back(mk(1'b1, 10'd1, 64'h00000033_00000000, 1'b1));
    beat(0, 32'h11, 0, 0);
    beat(0, 32'h22, 0, 0);
    beat(0, 32'h33, 1, 0);
    repeat (3) @(negedge clk);
    chk("t37_prog_len", {53'd0, plen_a}, 64'd2);
    chk("t37_err_odd",  {63'd0, eodd_a}, 64'd1);
    chk("t37_err_ovf",  {63'd0, eovf_a}, 64'd0);

    // Throttled valid
    pulse(0);
    chk("t39_err_odd_cleared", {63'd0, eodd_a}, 64'd0);
    qa.push_back(mk(1'b1, 10'd0, 64'hC0000000_C0000001, 1'b0));
    qa.push_back(mk(1'b1, 10'd1, 64'hC0000002_C0000003, 1'b0));
    qa.push_back(mk(1'b1, 10'd2, 64'hC0000004_C0000005, 1'b1));
    for (int k = 0; k < 6; k++) beat(0, 32'hC0000000 + k, k == 5, 1);
    repeat (3) @(negedge clk);
    chk("t39_prog_len", {53'd0, plen_a}, 64'd3);

    // Second start mid-load is ignored
    pulse(0);
    qa.push_back(mk(1'b1, 10'd0, 64'h5A000000_5A000001, 1'b0));
    qa.push_back(mk(1'b1, 10'd1, 64'h5A000002_5A000003, 1'b1));
    beat(0, 32'h5A000000, 0, 0);
    beat(0, 32'h5A000001, 0, 0);
    repeat (2) @(negedge clk);
    chk("t41_prog_len_mid", {53'd0, plen_a}, 64'd1);
    pulse(0);
    chk("t41_prog_len_after_start", {53'd0, plen_a}, 64'd1);
    chk("t41_busy", {63'd0, busy_a}, 64'd1);
    beat(0, 32'h5A000002, 0, 0);
    beat(0, 32'h5A000003, 1, 0);
    repeat (3) @(negedge clk);
    chk("t41_prog_len", {53'd0, plen_a}, 64'd2);

    // Overflow on the DEPTH=4 instance
    pulse(1);
    for (int i = 0; i < 4; i++)
      qb.push_back(mk(1'b1, 10'(i), {32'hD0000000 + 32'(2*i), 32'hD0000000 + 32'(2*i+1)}, 1'b0));
    qb.push_back(mk(1'b0, 10'd0, 64'd0, 1'b1));
    for (int k = 0; k < 20; k++) beat(1, 32'hD0000000 + k, k == 19, 0);
    repeat (3) @(negedge clk);
    chk("t38_prog_len", {60'd0, plen_b}, 64'd4);
    chk("t38_err_ovf",  {63'd0, eovf_b}, 64'd1);
    chk("t38_err_odd",  {63'd0, eodd_b}, 64'd0);
    chk("t38_busy",     {63'd0, busy_b}, 64'd0);

    // Reset mid-load, then reload from address 0
    pulse(0);
    qa.push_back(mk(1'b1, 10'd0, 64'hE0000000_E0000001, 1'b0));
    beat(0, 32'hE0000000, 0, 0);
    beat(0, 32'hE0000001, 0, 0);
    beat(0, 32'hE0000002, 0, 0);
    rst = 1'b1;
    #1;
    check_reset_a("t40_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse(0);
    qa.push_back(mk(1'b1, 10'd0, 64'hF0000000_F0000001, 1'b1));
    beat(0, 32'hF0000000, 0, 0);
    beat(0, 32'hF0000001, 1, 0);
    repeat (5) @(negedge clk);
    chk("t40_prog_len", {53'd0, plen_a}, 64'd1);

    chk("queue_a_empty", 64'(qa.size()), 64'd0);
    chk("queue_b_empty", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
